// File: rtl/regfile_write_arbiter_pkg.sv
// ============================================================================
// Package : regfile_pkg
// Shared constants, requester IDs and helpers for the register-file write
// arbiter slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int CNT_W    = 16;

  // R0 is hardwired to zero, so writes to it never reach the register file
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_AUX  = 1'b1
  } req_id_t;

  // Saturating increment for the statistics counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
// ============================================================================
// Interface : regfile_write_arbiter_if
// Requester handshakes, issue-mark port, register-file write port and the
// pending-write scoreboard of the write arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_write_arbiter_if;
  import regfile_pkg::*;

  logic                req0_valid;
  logic                req0_ready;
  logic [ADDR_W-1:0]   req0_rd;
  logic [DATA_W-1:0]   req0_data;
  logic                req1_valid;
  logic                req1_ready;
  logic [ADDR_W-1:0]   req1_rd;
  logic [DATA_W-1:0]   req1_data;
  logic                mark_valid;
  logic [ADDR_W-1:0]   mark_rd;
  logic [ADDR_W-1:0]   rf_rd;
  logic [DATA_W-1:0]   rf_write_value;
  logic                rf_regwrite;
  logic [NUM_REGS-1:0] pending;

  // Requesters, issue logic and register file side
  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    output mark_valid, mark_rd,
    input  req0_ready, req1_ready,
    input  rf_rd, rf_write_value, rf_regwrite, pending
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    input  mark_valid, mark_rd,
    output req0_ready, req1_ready,
    output rf_rd, rf_write_value, rf_regwrite, pending
  );

endinterface

`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// ============================================================================
// Module : rr_arbiter2
// Two-way round-robin grant. Ready is combinational from the valids and the
// last granted requester; the last-grant state moves only on a transfer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
  import regfile_pkg::*;
(
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic valid0_i,
  input  wire logic valid1_i,
  output logic      ready0_o,
  output logic      ready1_o
);

  req_id_t last_grant_q;
  req_id_t last_grant_d;

  // Grant the lone requester, or on contention the one that did not win last
  always_comb begin
    ready0_o     = valid0_i && (!valid1_i || (last_grant_q == REQ_AUX));
    ready1_o     = valid1_i && (!valid0_i || (last_grant_q == REQ_CORE));
    last_grant_d = last_grant_q;
    if (ready0_o) begin
      last_grant_d = REQ_CORE;
    end else if (ready1_o) begin
      last_grant_d = REQ_AUX;
    end
  end

  // Reset to AUX so the core path wins the first contention
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= REQ_AUX;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module : regfile_write_arbiter
// Shares the register-file write port between the core writeback path (req0)
// and the load/debug path (req1) with a registered output stage and a
// pending-write scoreboard for RAW hazard detection in decode.
// Optional macro: REGFILE_ARB_STATS_EN adds saturating grant/R0-drop counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter
  import regfile_pkg::*;
(
  input  wire logic                 clk,
  input  wire logic                 reset,
  regfile_write_arbiter_if.slave    bus
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]          grant0_cnt,
  output logic [CNT_W-1:0]          grant1_cnt,
  output logic [CNT_W-1:0]          r0_drop_cnt
`endif
);

  logic                w_ready0;
  logic                w_ready1;
  logic                w_xfer;
  logic [ADDR_W-1:0]   w_sel_rd;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_commit;

  logic [ADDR_W-1:0]   rf_rd_q;
  logic [DATA_W-1:0]   rf_value_q;
  logic                rf_regwrite_q;
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .valid0_i (bus.req0_valid),
    .valid1_i (bus.req1_valid),
    .ready0_o (w_ready0),
    .ready1_o (w_ready1)
  );

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;

  // Ready already implies valid, so any ready is a transfer this edge
  always_comb begin
    w_xfer     = w_ready0 || w_ready1;
    w_sel_rd   = w_ready0 ? bus.req0_rd   : bus.req1_rd;
    w_sel_data = w_ready0 ? bus.req0_data : bus.req1_data;
    w_commit   = w_xfer && (w_sel_rd != REG_ZERO);
  end

  // Output stage: one-cycle regwrite pulse; R0 writes are swallowed here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_regwrite_q <= 1'b0;
      rf_rd_q       <= '0;
      rf_value_q    <= '0;
    end else begin
      rf_regwrite_q <= w_commit;
      if (w_commit) begin
        rf_rd_q    <= w_sel_rd;
        rf_value_q <= w_sel_data;
      end
    end
  end

  // Scoreboard next state: commit clears first so a same-cycle mark wins
  always_comb begin
    pending_d = pending_q;
    if (rf_regwrite_q) begin
      pending_d[rf_rd_q] = 1'b0;
    end
    if (bus.mark_valid && (bus.mark_rd != REG_ZERO)) begin
      pending_d[bus.mark_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Scoreboard state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign bus.rf_rd          = rf_rd_q;
  assign bus.rf_write_value = rf_value_q;
  assign bus.rf_regwrite    = rf_regwrite_q;
  assign bus.pending        = pending_q;

`ifdef REGFILE_ARB_STATS_EN
  logic [CNT_W-1:0] grant0_q;
  logic [CNT_W-1:0] grant1_q;
  logic [CNT_W-1:0] r0_drop_q;

  // Per-requester transfer counts and accepted-but-dropped R0 writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant0_q  <= '0;
      grant1_q  <= '0;
      r0_drop_q <= '0;
    end else begin
      if (w_ready0) grant0_q <= sat_inc(grant0_q);
      if (w_ready1) grant1_q <= sat_inc(grant1_q);
      if (w_xfer && !w_commit) r0_drop_q <= sat_inc(r0_drop_q);
    end
  end

  assign grant0_cnt  = grant0_q;
  assign grant1_cnt  = grant1_q;
  assign r0_drop_cnt = r0_drop_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================================
// Module : tb_regfile_write_arbiter
// Self-checking bench: directed scenarios plus randomized traffic, with an
// expected-write queue drained by an independent register-file monitor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_write_arbiter_if bus ();

`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] grant0_cnt, grant1_cnt, r0_drop_cnt;
`endif

  regfile_write_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus)
`ifdef REGFILE_ARB_STATS_EN
    ,
    .grant0_cnt  (grant0_cnt),
    .grant1_cnt  (grant1_cnt),
    .r0_drop_cnt (r0_drop_cnt)
`endif
  );

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;

  // Reference model state
  int          m_last_winner = 1;
  logic [15:0] m_pend        = '0;
  bit          m_commit_v    = 1'b0;
  logic [3:0]  m_commit_rd   = '0;
  int          m_g0 = 0, m_g1 = 0, m_r0 = 0;
  int          wait0 = 0, wait1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Register-file monitor: every regwrite must match the oldest expected write
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.rf_regwrite === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rf_unexpected_write: got rd=%0d data=%h expected no write", bus.rf_rd, bus.rf_write_value);
        end else begin
          e = exp_q.pop_front();
          chk("rf_rd", 32'(bus.rf_rd), 32'(e.rd));
          chk("rf_write_value", bus.rf_write_value, e.data);
          chk("rf_latency", 32'(cyc - 1), 32'(e.cyc));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL rf_missing_write: got no regwrite expected rd=%0d data=%h", e.rd, e.data);
      end
    end
  end

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_rd = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_rd = '0; bus.req1_data = '0;
    bus.mark_valid = 1'b0; bus.mark_rd = '0;
  endtask

  // One bus cycle: drive after the edge, check readiness and scoreboard at the
  // falling edge, then advance the reference model across the next edge.
  task automatic cycle(input bit v0, input logic [3:0] rd0, input logic [31:0] d0,
                       input bit v1, input logic [3:0] rd1, input logic [31:0] d1,
                       input bit mv, input logic [3:0] mrd,
                       output bit g0, output bit g1);
    bit          e0, e1;
    logic [15:0] nxt;
    logic [3:0]  wrd;
    logic [31:0] wdat;
    @(posedge clk); #1;
    bus.req0_valid = v0; bus.req0_rd = rd0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_rd = rd1; bus.req1_data = d1;
    bus.mark_valid = mv; bus.mark_rd = mrd;
    @(negedge clk);
    // A lone requester always wins; under contention the previous loser wins
    e0 = v0 && (!v1 || m_last_winner == 1);
    e1 = v1 && (!v0 || m_last_winner == 0);
    chk("req0_ready", 32'(bus.req0_ready), 32'(e0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(e1));
    chk("pending", 32'(bus.pending), 32'(m_pend));
    chk("ready_exclusive", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
    if (v0 && !bus.req0_ready) wait0++; else wait0 = 0;
    if (v1 && !bus.req1_ready) wait1++; else wait1 = 0;
    if (wait0 > 1) chk("req0_wait_bound", 32'(wait0), 32'd1);
    if (wait1 > 1) chk("req1_wait_bound", 32'(wait1), 32'd1);
    nxt = m_pend;
    if (m_commit_v) nxt[m_commit_rd] = 1'b0;
    if (mv && mrd != 4'd0) nxt[mrd] = 1'b1;
    m_commit_v = 1'b0;
    if (e0 || e1) begin
      m_last_winner = e0 ? 0 : 1;
      wrd  = e0 ? rd0 : rd1;
      wdat = e0 ? d0 : d1;
      if (e0) m_g0++; else m_g1++;
      if (wrd != 4'd0) begin
        exp_q.push_back('{rd: wrd, data: wdat, cyc: cyc});
        m_commit_v  = 1'b1;
        m_commit_rd = wrd;
      end else begin
        m_r0++;
      end
    end
    m_pend = nxt;
    g0 = e0;
    g1 = e1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_last_winner = 1; m_pend = '0; m_commit_v = 1'b0;
    m_g0 = 0; m_g1 = 0; m_r0 = 0; wait0 = 0; wait1 = 0;
  endtask

  // Reset asserted just after an edge; outputs must clear without a clock
  task automatic pulse_reset();
    @(posedge clk); #1;
    chk("pending_before_reset", 32'(bus.pending), 32'(m_pend));
    reset = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    chk("reset_rf_regwrite", 32'(bus.rf_regwrite), 32'd0);
    chk("reset_pending", 32'(bus.pending), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit g0, g1;
    bit h0v, h1v;
    logic [3:0]  h0rd, h1rd;
    logic [31:0] h0d, h1d;
    idle_inputs();
    #2;
    chk("init_rf_regwrite", 32'(bus.rf_regwrite), 32'd0);
    chk("init_rf_rd", 32'(bus.rf_rd), 32'd0);
    chk("init_rf_write_value", bus.rf_write_value, 32'd0);
    chk("init_pending", 32'(bus.pending), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single write to R2
    cycle(1, 4'd2, 32'hAAAA_BBBB, 0, 4'd0, 32'd0, 0, 4'd0, g0, g1);
    repeat (2) cycle(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0, 4'd0, g0, g1);

    // Contention straight out of reset: core first, then aux
    pulse_reset();
    cycle(1, 4'd3, 32'hCCCC_DDDD, 1, 4'd4, 32'h1234_5678, 0, 4'd0, g0, g1);
    cycle(0, 4'd0, 32'd0, 1, 4'd4, 32'h1234_5678, 0, 4'd0, g0, g1);

    // Sustained contention with fresh data on every transfer
    for (int i = 0; i < 6; i++)
      cycle(1, 4'(7 + i), 32'h1000_0000 + i, 1, 4'(8 + i), 32'h2000_0000 + i, 0, 4'd0, g0, g1);

    // Write to R0 is accepted but never reaches the register file
    cycle(0, 4'd0, 32'd0, 1, 4'd0, 32'hDEAD_BEEF, 0, 4'd0, g0, g1);

    // Scoreboard: mark, commit with simultaneous re-mark, plain commit, mark R0
    cycle(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 1, 4'd5, g0, g1);
    cycle(1, 4'd5, 32'h5555_0001, 0, 4'd0, 32'd0, 0, 4'd0, g0, g1);
    cycle(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 1, 4'd5, g0, g1);
    cycle(1, 4'd5, 32'h5555_0002, 0, 4'd0, 32'd0, 0, 4'd0, g0, g1);
    cycle(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0, 4'd0, g0, g1);
    cycle(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 1, 4'd0, g0, g1);
    cycle(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0, 4'd0, g0, g1);

    // Reset while the output stage holds R6, then contention must favour req0
    cycle(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 1, 4'd9, g0, g1);
    cycle(1, 4'd6, 32'h9876_5432, 0, 4'd0, 32'd0, 1, 4'd6, g0, g1);
    pulse_reset();
    cycle(1, 4'd1, 32'h0101_0101, 1, 4'd2, 32'h0202_0202, 0, 4'd0, g0, g1);
    cycle(0, 4'd0, 32'd0, 1, 4'd2, 32'h0202_0202, 0, 4'd0, g0, g1);

    // Randomized traffic; requesters hold rd/data until transfer or withdrawal
    h0v = 0; h1v = 0; h0rd = '0; h1rd = '0; h0d = '0; h1d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!h0v) begin
        h0v = ($urandom_range(0, 2) != 0);
        h0rd = 4'($urandom_range(0, 15));
        h0d = $urandom;
      end else if ($urandom_range(0, 9) == 0) begin
        h0v = 0;
      end
      if (!h1v) begin
        h1v = ($urandom_range(0, 2) != 0);
        h1rd = 4'($urandom_range(0, 15));
        h1d = $urandom;
      end else if ($urandom_range(0, 9) == 0) begin
        h1v = 0;
      end
      cycle(h0v, h0rd, h0d, h1v, h1rd, h1d,
            ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), g0, g1);
      if (g0) h0v = 0;
      if (g1) h1v = 0;
    end

    repeat (3) cycle(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0, 4'd0, g0, g1);
    chk("expected_queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef REGFILE_ARB_STATS_EN
    chk("grant0_cnt", 32'(grant0_cnt), 32'(m_g0));
    chk("grant1_cnt", 32'(grant1_cnt), 32'(m_g1));
    chk("r0_drop_cnt", 32'(r0_drop_cnt), 32'(m_r0));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (Rd / write_value / regwrite) between two writeback requesters: req0 is the core writeback path and req1 is the load/debug path.
- Uses round-robin arbitration with valid/ready handshakes and one registered output stage in front of the register file.
- Keeps a pending-write scoreboard so decode can detect read-after-write hazards on Rs/Rt.
- Sits between the multi-cycle control/writeback logic and the register file.

Parameters:
- ADDR_W, 4, register address width (Rd/Rs/Rt).
- DATA_W, 32, register data width.
- NUM_REGS, 16, number of architectural registers (2**ADDR_W).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  core writeback request.
- req0_ready  out  1  req0 accepted this cycle.
- req0_rd  in  ADDR_W  destination register.
- req0_data  in  DATA_W  write data.
- req1_valid / req1_ready / req1_rd / req1_data  same widths and meaning, for the load/debug requester.
- mark_valid  in  1  issue marks a destination as pending.
- mark_rd  in  ADDR_W  register to mark.
- rf_rd  out  ADDR_W  to register file Rd.
- rf_write_value  out  DATA_W  to register file write_value.
- rf_regwrite  out  1  to register file regwrite.
- pending  out  NUM_REGS  scoreboard; bit i=1 means a write to Ri is outstanding.

Behaviour:
- Reset: rf_regwrite=0, rf_rd=0, rf_write_value=0, pending=0. last_grant=1, so req0 wins the first contention.
- ready signals: combinational from the valids and last_grant.
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester not equal to last_grant gets ready=1.
  - Never both ready in the same cycle.
- Transfer: occurs on valid&ready at a rising edge. Requesters hold rd/data stable until their transfer. A deasserted valid without a transfer is legal (request withdrawn).
- last_grant updates only on a transfer. Fairness: a continuously valid requester waits at most 1 cycle.
- Output stage, latency 1: the cycle after a transfer, rf_rd and rf_write_value hold the accepted rd/data and rf_regwrite=1. With no transfer, rf_regwrite=0 and rf_rd/rf_write_value keep their last values.
- Writes to R0 (rd==0) are accepted (ready=1, last_grant updates) but rf_regwrite stays 0 that cycle.
- Scoreboard:
  - mark_valid with mark_rd!=0 sets pending[mark_rd] at the edge.
  - A committing write (rf_regwrite=1) clears pending[rf_rd] at the edge.
  - Same register set and cleared in the same cycle: set wins (the new producer is outstanding).
  - pending[0] is constant 0; mark_rd==0 is ignored.
  - Clearing a bit that is not set is harmless.
- Reset mid-operation: an in-flight output-stage write is dropped (rf_regwrite forced 0 asynchronously) and all pending bits are cleared.
- No internal FIFO; backpressure is purely via ready.

Optional Feature:
- REGFILE_ARB_STATS_EN defined:
  - Adds outputs grant0_cnt and grant1_cnt (16 bit each), counting transfers per requester, saturating at 16'hFFFF.
  - Adds output r0_drop_cnt (16 bit, saturating), counting accepted rd==0 writes.
  - All counters reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package regfile_pkg: ADDR_W, DATA_W and NUM_REGS constants, the REG_ZERO constant, and the requester-ID typedef (REQ_CORE=0, REQ_AUX=1).
- One natural sub-module, rr_arbiter2: the 2-way round-robin grant with last_grant state.
- The scoreboard and output stage stay in the top module.

Test Plan:
- Single write: req0 rd=2, data=AAAA_BBBB for one cycle -> req0_ready=1; next cycle rf_regwrite=1, rf_rd=2, rf_write_value=AAAA_BBBB; the following cycle rf_regwrite=0.
- Contention: req0 (rd=3, CCCC_DDDD) and req1 (rd=4, 1234_5678) both valid from reset -> req0 granted first; req1 granted the next cycle; rf writes R3 then R4 in consecutive cycles.
- Sustained contention: both valid for 6 cycles with new data each transfer -> grants alternate 0,1,0,1,0,1; neither requester waits more than 1 cycle.
- R0 write: req1 rd=0, DEAD_BEEF -> req1_ready=1; rf_regwrite stays 0; with REGFILE_ARB_STATS_EN, r0_drop_cnt=1.
- Scoreboard: mark rd=5 -> pending[5]=1. req0 write to R5 plus a simultaneous mark of rd=5 in the commit cycle -> pending[5] remains 1. A later commit with no mark -> pending[5]=0. Mark rd=0 -> pending stays 0.
- Reset mid-operation: assert reset in the cycle after a transfer (output stage holding R6 / 9876_5432) -> rf_regwrite drops to 0 immediately and pending=0; after release, the first contention grants req0.
